present_encrypt_ctrl: RTL

- Sequencing controller for the iterative PRESENT-80 encryption core. It owns the master-key store, accepts plaintext blocks over a valid/ready interface and drives the core's key_load/data_load/data_i pins.
- It counts the 31 round cycles, captures the ciphertext into a one-entry output buffer and presents it over a valid/ready interface.
- The core's key register is consumed by the round-key updates, so the controller reloads the stored master key before every block.

---
 rtl/present_encrypt_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/present_encrypt_ctrl.sv
// Sequencing controller for an iterative PRESENT-80 core: holds the master key,
// reloads it before every block, counts rounds and buffers one ciphertext.
module present_encrypt_ctrl #(
  parameter int unsigned ROUNDS = 31,
  parameter int unsigned CNT_W  = 5
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        key_valid_i,
  output logic        key_ready_o,
  input  logic [79:0] key_i,
  input  logic        pt_valid_i,
  output logic        pt_ready_o,
  input  logic [63:0] pt_i,
  output logic        ct_valid_o,
  input  logic        ct_ready_i,
  output logic [63:0] ct_o,
  output logic        busy_o,
  output logic        key_set_o,
  output logic [79:0] core_data_o,
  output logic        core_key_load_o,
  output logic        core_data_load_o,
  input  logic [63:0] core_ct_i
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_KEY,
    LOAD_DATA,
    ROUND,
    CAPTURE
  } state_e;

  state_e             state_q, state_d;
  logic [79:0]        key_q, key_d;
  logic [63:0]        pt_q, pt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               key_set_q, key_set_d;
  logic               ct_valid_q, ct_valid_d;
  logic [63:0]        ct_q, ct_d;
  logic               key_load_q, key_load_d;
  logic               data_load_q, data_load_d;
  logic [79:0]        core_data_q, core_data_d;
  logic               key_hs;
  logic               pt_hs;

  assign key_ready_o      = (state_q == IDLE);
  // A pending key write takes priority; the output buffer must be free or draining.
  assign pt_ready_o       = (state_q == IDLE) && key_set_q && !key_valid_i &&
                            (!ct_valid_q || ct_ready_i);
  assign key_hs           = key_valid_i && key_ready_o;
  assign pt_hs            = pt_valid_i && pt_ready_o;

  assign ct_valid_o       = ct_valid_q;
  assign ct_o             = ct_q;
  assign busy_o           = (state_q != IDLE);
  assign key_set_o        = key_set_q;
  assign core_data_o      = core_data_q;
  assign core_key_load_o  = key_load_q;
  assign core_data_load_o = data_load_q;

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    pt_d        = pt_q;
    cnt_d       = cnt_q;
    key_set_d   = key_set_q;
    ct_valid_d  = ct_valid_q;
    ct_d        = ct_q;
    key_load_d  = 1'b0;
    data_load_d = 1'b0;
    core_data_d = '0;

    if (ct_valid_q && ct_ready_i) begin
      ct_valid_d = 1'b0;
    end

    // Core pins are registered, so they are set up on the transition into each load state.
    case (state_q)
      IDLE: begin
        if (key_hs) begin
          key_d     = key_i;
          key_set_d = 1'b1;
        end
        if (pt_hs) begin
          pt_d        = pt_i;
          state_d     = LOAD_KEY;
          key_load_d  = 1'b1;
          core_data_d = key_q;
        end
      end
      LOAD_KEY: begin
        state_d     = LOAD_DATA;
        data_load_d = 1'b1;
        core_data_d = {16'h0000, pt_q};
      end
      LOAD_DATA: begin
        state_d = ROUND;
        cnt_d   = '0;
      end
      ROUND: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ROUNDS - 1)) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        ct_d       = core_ct_i;
        ct_valid_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      key_q       <= '0;
      pt_q        <= '0;
      cnt_q       <= '0;
      key_set_q   <= 1'b0;
      ct_valid_q  <= 1'b0;
      ct_q        <= '0;
      key_load_q  <= 1'b0;
      data_load_q <= 1'b0;
      core_data_q <= '0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      pt_q        <= pt_d;
      cnt_q       <= cnt_d;
      key_set_q   <= key_set_d;
      ct_valid_q  <= ct_valid_d;
      ct_q        <= ct_d;
      key_load_q  <= key_load_d;
      data_load_q <= data_load_d;
      core_data_q <= core_data_d;
    end
  end

endmodule
